// File: rtl/search_and_add_multi_if.sv
// Bus bundle for search_and_add_multi: record push, batch control and result write port.
interface search_and_add_multi_if #(
    parameter int KEY_W = 128,
    parameter int VAL_W = 32
);
    logic                   ready;
    logic                   clear;
    logic                   kick;
    logic                   busy;
    logic [7:0]             data_num;
    logic [KEY_W+VAL_W-1:0] din;
    logic                   we;
    logic                   full;
    logic                   mode;
    logic [15:0]            overflow_cnt;
    logic [31:0]            accum_addr;
    logic [63:0]            accum_din;
    logic                   accum_we;

    modport slave (
        output ready, busy, full, overflow_cnt, accum_addr, accum_din, accum_we,
        input  clear, kick, data_num, din, we, mode
    );

    modport master (
        input  ready, busy, full, overflow_cnt, accum_addr, accum_din, accum_we,
        output clear, kick, data_num, din, we, mode
    );
endinterface

// File: rtl/search_and_add_multi.sv
// Wordcount accumulator: input record FIFO feeding a fully-associative key table.
// Each batch record is processed in FETCH -> MATCH -> UPDATE; updates are mirrored on accum_*.
module search_and_add_multi #(
    parameter int KEY_W    = 128,
    parameter int VAL_W    = 32,
    parameter int ACC_W    = 64,
    parameter int ENTRIES  = 16,
    parameter int FIFO_DEP = 16,
    parameter int SATURATE = 0
) (
    input logic                  clk,
    input logic                  reset,
    search_and_add_multi_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int FP_W  = $clog2(FIFO_DEP);
    localparam int REC_W = KEY_W + VAL_W;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_FETCH, S_MATCH, S_UPDATE} state_t;
    state_t state, state_nx;

    logic [REC_W-1:0] fifo_mem [FIFO_DEP];
    logic [FP_W-1:0]  wr_ptr, rd_ptr;
    logic [FP_W:0]    fifo_cnt;
    logic             fifo_full, push, pop;

    logic [KEY_W-1:0] keys [ENTRIES];
    logic [ACC_W-1:0] acc  [ENTRIES];
    logic [ENTRIES-1:0] valid;
    logic [IDX_W:0]   free_ptr;
    logic [IDX_W-1:0] init_cnt;

    logic [REC_W-1:0] rec;
    logic [KEY_W-1:0] rec_key;
    logic [VAL_W-1:0] rec_val;
    logic [7:0]       rem, kick_rem;
    logic             mode_r, hit_r, m_hit, tbl_full;
    logic [IDX_W-1:0] idx_r, m_idx, wr_idx;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] add_res, new_acc;
    logic             do_write, alloc, clr_go, kick_go;
    logic [15:0]      ovf_cnt;
    logic             accum_we_r;
    logic [31:0]      accum_addr_r;
    logic [63:0]      accum_din_r;

    assign fifo_full = (fifo_cnt == (FP_W+1)'(FIFO_DEP));
    assign push      = bus.we && !fifo_full;
    assign pop       = (state == S_FETCH);
    assign rec_key   = rec[REC_W-1:VAL_W];
    assign rec_val   = rec[VAL_W-1:0];
    assign tbl_full  = free_ptr[IDX_W];
    assign kick_rem  = (32'(fifo_cnt) < 32'(bus.data_num)) ? 8'(fifo_cnt) : bus.data_num;

    // FIFO pointers and occupancy; pushes accepted in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + (FP_W+1)'(push) - (FP_W+1)'(pop);
        end
    end

    // Storage arrays without reset: FIFO payload, record register, keys, accumulators.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (push) fifo_mem[wr_ptr] <= bus.din;
            if (state == S_FETCH) rec <= fifo_mem[rd_ptr];
            if (alloc) keys[free_ptr[IDX_W-1:0]] <= rec_key;
            if (state == S_INIT && !bus.clear) acc[init_cnt] <= '0;
            else if (do_write) acc[wr_idx] <= new_acc;
        end
    end

    // Parallel key compare; descending scan leaves the lowest matching slot.
    always_comb begin
        m_hit = 1'b0;
        m_idx = '0;
        for (int unsigned i = ENTRIES; i > 0; i--) begin
            if (valid[i-1] && keys[i-1] == rec_key) begin
                m_hit = 1'b1;
                m_idx = IDX_W'(i - 1);
            end
        end
    end

    // New slot value and write decision for the UPDATE cycle.
    always_comb begin
        sum      = {1'b0, acc[idx_r]} + (ACC_W+1)'(rec_val);
        add_res  = (SATURATE != 0 && sum[ACC_W]) ? '1 : sum[ACC_W-1:0];
        new_acc  = (hit_r && !mode_r) ? add_res : ACC_W'(rec_val);
        wr_idx   = hit_r ? idx_r : free_ptr[IDX_W-1:0];
        do_write = (state == S_UPDATE) && (hit_r || !tbl_full);
        alloc    = (state == S_UPDATE) && !hit_r && !tbl_full;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_INIT;
        else       state <= state_nx;
    end

    // Next-state logic; clear wins over kick in IDLE.
    always_comb begin
        state_nx = state;
        clr_go   = 1'b0;
        kick_go  = 1'b0;
        case (state)
            S_INIT: begin
                if (bus.clear) clr_go = 1'b1;
                else if (init_cnt == IDX_W'(ENTRIES - 1)) state_nx = S_IDLE;
            end
            S_IDLE: begin
                if (bus.clear) begin
                    clr_go   = 1'b1;
                    state_nx = S_INIT;
                end else if (bus.kick && kick_rem != 8'd0) begin
                    kick_go  = 1'b1;
                    state_nx = S_FETCH;
                end
            end
            S_FETCH:  state_nx = S_MATCH;
            S_MATCH:  state_nx = S_UPDATE;
            S_UPDATE: state_nx = (rem == 8'd1) ? S_IDLE : S_FETCH;
            default:  state_nx = S_INIT;
        endcase
    end

    // Batch control, table bookkeeping and registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid        <= '0;
            free_ptr     <= '0;
            init_cnt     <= '0;
            rem          <= '0;
            mode_r       <= 1'b0;
            hit_r        <= 1'b0;
            idx_r        <= '0;
            ovf_cnt      <= '0;
            accum_we_r   <= 1'b0;
            accum_addr_r <= '0;
            accum_din_r  <= '0;
        end else begin
            accum_we_r <= do_write;
            if (do_write) begin
                accum_addr_r <= 32'(wr_idx);
                accum_din_r  <= 64'(new_acc);
            end
            if (clr_go) begin
                valid    <= '0;
                free_ptr <= '0;
                init_cnt <= '0;
            end else if (state == S_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
            if (kick_go) begin
                rem    <= kick_rem;
                mode_r <= bus.mode;
            end
            if (state == S_MATCH) begin
                hit_r <= m_hit;
                idx_r <= m_idx;
            end
            if (state == S_UPDATE) begin
                rem <= rem - 1'b1;
                if (alloc) begin
                    valid[free_ptr[IDX_W-1:0]] <= 1'b1;
                    free_ptr <= free_ptr + 1'b1;
                end else if (!hit_r && ovf_cnt != 16'hFFFF) begin
                    ovf_cnt <= ovf_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.ready        = (state != S_INIT);
    assign bus.busy         = (state == S_FETCH) || (state == S_MATCH) || (state == S_UPDATE);
    assign bus.full         = fifo_full;
    assign bus.overflow_cnt = ovf_cnt;
    assign bus.accum_we     = accum_we_r;
    assign bus.accum_addr   = accum_addr_r;
    assign bus.accum_din    = accum_din_r;
endmodule

// File: tb/tb_search_and_add_multi.sv
// Bench: a wrapping and a saturating instance share stimulus; expected writes queued per DUT.
module tb_search_and_add_multi;
    localparam int KW = 16;
    localparam int VW = 32;
    localparam int AW = 32;
    localparam int E  = 4;
    localparam int FD = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    search_and_add_multi_if #(.KEY_W(KW), .VAL_W(VW)) if0 ();
    search_and_add_multi_if #(.KEY_W(KW), .VAL_W(VW)) if1 ();

    assign if1.clear    = if0.clear;
    assign if1.kick     = if0.kick;
    assign if1.data_num = if0.data_num;
    assign if1.din      = if0.din;
    assign if1.we       = if0.we;
    assign if1.mode     = if0.mode;

    search_and_add_multi #(.KEY_W(KW), .VAL_W(VW), .ACC_W(AW), .ENTRIES(E), .FIFO_DEP(FD), .SATURATE(0))
        dut0 (.clk(clk), .reset(reset), .bus(if0));
    search_and_add_multi #(.KEY_W(KW), .VAL_W(VW), .ACC_W(AW), .ENTRIES(E), .FIFO_DEP(FD), .SATURATE(1))
        dut1 (.clk(clk), .reset(reset), .bus(if1));

    typedef struct {
        logic [31:0] addr;
        logic [63:0] din;
    } wr_t;

    typedef struct {
        logic [KW-1:0] key;
        logic [VW-1:0] val;
        logic          md;
        logic [7:0]    num;   // 0: push only, no kick
        logic          we_exp;
        logic [31:0]   addr;
        logic [63:0]   d0;    // wrapping instance
        logic [63:0]   d1;    // saturating instance
        logic [15:0]   ovf;
    } vec_t;

    wr_t  q0[$];
    wr_t  q1[$];
    vec_t vecs[11];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Scoreboard: every write strobe pops one expected write per instance.
    always @(negedge clk) begin
        wr_t e;
        if (if0.accum_we) begin
            if (q0.size() == 0) check("unexpected_wr0", 64'(if0.accum_we), 64'd0);
            else begin
                e = q0.pop_front();
                check("wr_addr0", 64'(if0.accum_addr), 64'(e.addr));
                check("wr_din0", if0.accum_din, e.din);
            end
        end
        if (if1.accum_we) begin
            if (q1.size() == 0) check("unexpected_wr1", 64'(if1.accum_we), 64'd0);
            else begin
                e = q1.pop_front();
                check("wr_addr1", 64'(if1.accum_addr), 64'(e.addr));
                check("wr_din1", if1.accum_din, e.din);
            end
        end
    end

    task automatic do_reset();
        int k;
        @(negedge clk);
        reset = 1'b1;
        if0.we = 1'b0; if0.kick = 1'b0; if0.clear = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(if0.ready), 64'd0);
        check("rst_busy", 64'(if0.busy), 64'd0);
        check("rst_full", 64'(if0.full), 64'd0);
        check("rst_accum_we", 64'(if0.accum_we), 64'd0);
        check("rst_accum_addr", 64'(if0.accum_addr), 64'd0);
        check("rst_accum_din", if0.accum_din, 64'd0);
        check("rst_ovf", 64'(if0.overflow_cnt), 64'd0);
        reset = 1'b0;
        k = 0;
        while (!if0.ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("ready_delay", 64'(k), 64'(E));
    endtask

    task automatic push(input logic [KW-1:0] key, input logic [VW-1:0] val,
                        input bit chk, input logic exp_full);
        @(negedge clk);
        if (chk) check("fifo_full", 64'(if0.full), 64'(exp_full));
        if0.din = {key, val};
        if0.we  = 1'b1;
        @(negedge clk);
        if0.we  = 1'b0;
    endtask

    task automatic do_kick(input logic [7:0] n, input logic md, input logic exp_go, input bit chk_lat);
        int k;
        @(negedge clk);
        if0.data_num = n;
        if0.mode     = md;
        if0.kick     = 1'b1;
        @(negedge clk);
        if0.kick = 1'b0;
        check("busy_after_kick", 64'(if0.busy), 64'(exp_go));
        k = 1;
        if (chk_lat) begin
            while (!if0.accum_we && k < 20) begin
                @(negedge clk);
                k++;
            end
            check("kick_latency", 64'(k), 64'd4);
        end
        k = 0;
        while (if0.busy && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("batch_done", 64'(if0.busy), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int k;
        vecs[0]  = '{16'h1111, 32'd5,          1'b0, 8'd0, 1'b1, 32'd0, 64'd5,          64'd5,          16'd0};
        vecs[1]  = '{16'h2222, 32'd7,          1'b0, 8'd2, 1'b1, 32'd1, 64'd7,          64'd7,          16'd0};
        vecs[2]  = '{16'h1111, 32'd3,          1'b0, 8'd1, 1'b1, 32'd0, 64'd8,          64'd8,          16'd0};
        vecs[3]  = '{16'h1111, 32'd9,          1'b1, 8'd1, 1'b1, 32'd0, 64'd9,          64'd9,          16'd0};
        vecs[4]  = '{16'h3333, 32'hFFFF_FFF0,  1'b0, 8'd1, 1'b1, 32'd2, 64'hFFFF_FFF0,  64'hFFFF_FFF0,  16'd0};
        vecs[5]  = '{16'h3333, 32'h20,         1'b0, 8'd1, 1'b1, 32'd2, 64'h10,         64'hFFFF_FFFF,  16'd0};
        vecs[6]  = '{16'h2222, 32'd1,          1'b0, 8'd0, 1'b1, 32'd1, 64'd8,          64'd8,          16'd0};
        vecs[7]  = '{16'h2222, 32'd2,          1'b0, 8'd2, 1'b1, 32'd1, 64'd10,         64'd10,         16'd0};
        vecs[8]  = '{16'h4444, 32'd4,          1'b0, 8'd5, 1'b1, 32'd3, 64'd4,          64'd4,          16'd0};
        vecs[9]  = '{16'h5555, 32'd6,          1'b0, 8'd1, 1'b0, 32'd0, 64'd0,          64'd0,          16'd1};
        vecs[10] = '{16'h1111, 32'd1,          1'b0, 8'd1, 1'b1, 32'd0, 64'd10,         64'd10,         16'd1};

        if0.we = 1'b0; if0.kick = 1'b0; if0.clear = 1'b0;
        if0.data_num = 8'd0; if0.mode = 1'b0; if0.din = '0;

        do_reset();

        // Kick with an empty FIFO: nothing starts.
        do_kick(8'd3, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 11; i++) begin
            push(vecs[i].key, vecs[i].val, 1'b0, 1'b0);
            if (vecs[i].we_exp) begin
                q0.push_back('{vecs[i].addr, vecs[i].d0});
                q1.push_back('{vecs[i].addr, vecs[i].d1});
            end
            if (vecs[i].num != 8'd0) begin
                do_kick(vecs[i].num, vecs[i].md, 1'b1, i == 1);
                check("ovf0", 64'(if0.overflow_cnt), 64'(vecs[i].ovf));
                check("ovf1", 64'(if1.overflow_cnt), 64'(vecs[i].ovf));
                check("pending_writes", 64'(q0.size() + q1.size()), 64'd0);
            end
        end

        // Clear in IDLE: table re-initialised, overflow count retained.
        @(negedge clk);
        if0.clear = 1'b1;
        @(negedge clk);
        if0.clear = 1'b0;
        check("clear_ready_low", 64'(if0.ready), 64'd0);
        k = 0;
        while (!if0.ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("clear_ready_delay", 64'(k), 64'(E));
        check("clear_ovf_kept", 64'(if0.overflow_cnt), 64'd1);
        push(16'h5555, 32'd6, 1'b0, 1'b0);
        q0.push_back('{32'd0, 64'd6});
        q1.push_back('{32'd0, 64'd6});
        do_kick(8'd1, 1'b0, 1'b1, 1'b0);
        check("pending_after_clear", 64'(q0.size() + q1.size()), 64'd0);

        // Overfill the FIFO; the ninth record is dropped, batch of 255 yields FD writes.
        for (int i = 0; i <= FD; i++) begin
            push(16'h5555, 32'd1, 1'b1, (i == FD));
            if (i < FD) begin
                q0.push_back('{32'd0, 64'(7 + i)});
                q1.push_back('{32'd0, 64'(7 + i)});
            end
        end
        do_kick(8'd255, 1'b0, 1'b1, 1'b0);
        check("pending_after_fill", 64'(q0.size() + q1.size()), 64'd0);
        check("fifo_empty_after", 64'(if0.full), 64'd0);

        // Reset mid-batch: after two writes no further strobes may appear.
        do_reset();
        for (int i = 0; i < FD; i++) begin
            push(16'h6666, 32'd1, 1'b0, 1'b0);
            q0.push_back('{32'd0, 64'(i + 1)});
            q1.push_back('{32'd0, 64'(i + 1)});
        end
        @(negedge clk);
        if0.data_num = 8'd255;
        if0.kick     = 1'b1;
        @(negedge clk);
        if0.kick = 1'b0;
        k = 0;
        while (q0.size() > FD - 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("midbatch_writes_seen", 64'(q0.size()), 64'(FD - 2));
        reset = 1'b1;
        q0.delete();
        q1.delete();
        repeat (3) @(negedge clk);
        check("midbatch_rst_busy", 64'(if0.busy), 64'd0);
        check("midbatch_rst_full", 64'(if0.full), 64'd0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("midbatch_idle", 64'(if0.busy), 64'd0);
        check("midbatch_ready", 64'(if0.ready), 64'd1);
        check("midbatch_ovf", 64'(if0.overflow_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
